key_debounce_multi: RTL and testbench
=====================================

# key_debounce_multi

Parametrised multi-channel key debouncer and event generator for the board push-button bank. It sits between the raw key pins and the control logic. It synchronises each key and debounces both press and release. It produces a debounced level plus single-cycle press, release and long-press pulses per channel, and a priority-encoded press code for consumers that handle one key at a time.

## Interface
- `N_KEYS`, 4: number of independent key channels (≥1).
- `DEBOUNCE_CYCLES`, 10000: consecutive stable samples required to accept a press or a release (≥1).
- `LONG_CYCLES`, 1000000: held cycles, counted from press acceptance, before `key_long` fires. 0 disables long-press.
- `ACTIVE_LOW`, 1: 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.
- `clk` input 1: single clock; all logic on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `key_in` input `N_KEYS`: raw, asynchronous key pins.
- `key_level` output `N_KEYS`: debounced pressed level (1 = pressed).
- `key_press` output `N_KEYS`: 1-cycle pulse on accepted press.
- `key_release` output `N_KEYS`: 1-cycle pulse on accepted release.
- `key_long` output `N_KEYS`: 1-cycle pulse, at most once per press.
- `key_code_valid` output 1: 1-cycle pulse when any `key_press` bit is high.
- `key_code` output `max(1,$clog2(N_KEYS))`: index of lowest-numbered channel pressing this cycle; 0 when not valid.

## Operation
- Per channel: 2-flop synchroniser on `key_in[i]`, then normalised so pressed = 1 (invert when `ACTIVE_LOW`=1). Call the result `p`.
- Per-channel FSM with `db_cnt` (debounce counter) and `hold_cnt` (saturating hold counter):
  - IDLE: if `p`=1 → PRESS_WAIT, `db_cnt`←0.
  - PRESS_WAIT:
    - `p`=0 → IDLE.
    - `p`=1 with `db_cnt`=`DEBOUNCE_CYCLES`−1 → HELD; `key_press` pulses; `hold_cnt`←0.
    - Otherwise `db_cnt`++.
  - HELD: if `p`=0 → RELEASE_WAIT, `db_cnt`←0.
  - RELEASE_WAIT:
    - `p`=1 → HELD. This is a release bounce: no pulse, `hold_cnt` not cleared.
    - `p`=0 with `db_cnt`=`DEBOUNCE_CYCLES`−1 → IDLE; `key_release` pulses.
    - Otherwise `db_cnt`++.
- `key_level`=1 exactly while the state is HELD or RELEASE_WAIT.
- Long press:
  - `hold_cnt` increments every cycle in HELD or RELEASE_WAIT and saturates at `LONG_CYCLES`.
  - `key_long` pulses in the cycle after `hold_cnt` reaches `LONG_CYCLES`−1 (when `LONG_CYCLES`>0).
  - Never pulses again before the next IDLE.
  - A release accepted before that point suppresses it.
- Encoder:
  - `key_code_valid` = OR of `key_press`.
  - `key_code` = lowest set index of `key_press`.
  - Both are combinational from registered pulses, so they are aligned with `key_press`.
- Width rules:
  - Counter widths are `$clog2(max+1)` of their limits.
  - No wrap: `db_cnt` is bounded by the FSM.
  - `hold_cnt` saturates.
- Simultaneous presses on several channels: each `key_press` bit asserts independently; only the lowest index is encoded.
- `key_press` and `key_long` for one channel never coincide; `key_long` may coincide with `key_release` of another channel.

## Timing
- Reset (async assert):
  - All FSMs → IDLE.
  - Counters → 0.
  - Synchroniser flops → the unpressed pin level.
  - All outputs 0.
  - No spurious press after reset, even if a key is held.
- Reset mid-press: the channel restarts at IDLE. A key still held afterwards is re-debounced and produces a fresh `key_press`.
- Press latency:
  - Let edge k be the first edge at which the synchroniser captures the pressed pin level.
  - `key_press` is high for the cycle following edge k+2+`DEBOUNCE_CYCLES`.
- Release latency: identical to press latency.
- A glitch shorter than `DEBOUNCE_CYCLES` samples produces no output.

## Structure
- Package `key_pkg`:
  - State enum {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT}.
  - Counter-width helper function.
- Sub-module `key_debounce_ch`:
  - One channel: synchroniser, FSM, counters, level and pulse outputs.
  - Instantiated `N_KEYS` times by generate.
- Top level holds only the generate loop and the priority encoder.

## Test plan
- Setup for all scenarios: `N_KEYS`=4, `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20, `ACTIVE_LOW`=1.
- Clean press: `key_in[0]` driven 0 before edge 10 and held.
  - `key_press[0]` high exactly the cycle after edge 16.
  - `key_level[0]`=1 from then.
  - `key_code_valid`=1 with `key_code`=0 in that same cycle.
- Bounce rejection: `key_in[1]` toggles with 3-cycle low / 1-cycle high pulses for 40 cycles. No `key_press`; `key_level[1]` stays 0.
- Long press and release: hold `key_in[2]` low for 40 cycles, including one 2-cycle high glitch mid-hold, then release.
  - One `key_press`.
  - One `key_long`, 20 cycles after `key_press`, despite the glitch.
  - One `key_release`, 6 cycles after the pin returns high.
- Simultaneous press: `key_in[3]` and `key_in[1]` pressed on the same edge.
  - Both `key_press` bits high in the same cycle.
  - `key_code`=1.
- Reset mid-hold: assert `rst_n`=0 while `key_level[0]`=1 with the key still held.
  - All outputs 0 immediately.
  - After deassertion, a fresh `key_press[0]` appears after the full latency.
  - No `key_release` pulse.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and helpers for the multi-channel key debouncer.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  // Bits needed to hold values 0..max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, press/release debounce FSM and
// saturating hold counter driving level, press, release and long-press pulses.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int LONG_CYCLES     = 1000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int DW = cnt_w(DEBOUNCE_CYCLES - 1);
  localparam int HW = cnt_w(LONG_CYCLES);
  localparam logic IDLE_PIN = (ACTIVE_LOW != 0);
  localparam logic LONG_EN  = (LONG_CYCLES > 0);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'((LONG_CYCLES > 0) ? LONG_CYCLES - 1 : 0);

  logic [1:0]    sync_q;
  logic          p;
  key_state_e    state;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  logic          in_hold;
  logic          rel_now;

  // Synchroniser resets to the unpressed pin level so a held key is not
  // seen as pressed until it has been re-debounced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {2{IDLE_PIN}};
    else        sync_q <= {sync_q[0], key_in};
  end

  assign p       = sync_q[1] ^ IDLE_PIN;
  assign in_hold = (state == HELD) || (state == RELEASE_WAIT);
  assign rel_now = (state == RELEASE_WAIT) && !p && (db_cnt == DB_LAST);
  assign level   = in_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      db_cnt        <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: if (p) begin
          state  <= PRESS_WAIT;
          db_cnt <= '0;
        end
        PRESS_WAIT:
          if (!p) state <= IDLE;
          else if (db_cnt == DB_LAST) begin
            state       <= HELD;
            press_pulse <= 1'b1;
          end else db_cnt <= db_cnt + DW'(1);
        HELD: if (!p) begin
          state  <= RELEASE_WAIT;
          db_cnt <= '0;
        end
        RELEASE_WAIT:
          if (p) state <= HELD;
          else if (rel_now) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
          end else db_cnt <= db_cnt + DW'(1);
        default: state <= IDLE;
      endcase
    end
  end

  // Hold counter survives release bounces; it is only cleared on a new press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt   <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      if (state == PRESS_WAIT && p && db_cnt == DB_LAST) begin
        hold_cnt <= '0;
      end else if (in_hold && hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + HW'(1);
        if (LONG_EN && hold_cnt == HOLD_LAST && !rel_now) long_pulse <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: per-channel debounce instances plus a
// priority encoder reporting the lowest-numbered key pressed this cycle.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int LONG_CYCLES     = 1000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [N_KEYS-1:0]                             key_in,
  output logic [N_KEYS-1:0]                             key_level,
  output logic [N_KEYS-1:0]                             key_press,
  output logic [N_KEYS-1:0]                             key_release,
  output logic [N_KEYS-1:0]                             key_long,
  output logic                                          key_code_valid,
  output logic [((N_KEYS > 1) ? $clog2(N_KEYS) : 1)-1:0] key_code
);

  localparam int CW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_in       (key_in[i]),
      .level        (key_level[i]),
      .press_pulse  (key_press[i]),
      .release_pulse(key_release[i]),
      .long_pulse   (key_long[i])
    );
  end

  // Scan from the top so the lowest set index wins.
  always_comb begin
    key_code       = '0;
    key_code_valid = |key_press;
    for (int i = N_KEYS - 1; i >= 0; i--)
      if (key_press[i]) key_code = CW'(i);
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi with short debounce/long limits.
module tb_key_debounce_multi;

  localparam int NK = 4;

  logic          clk;
  logic          rst_n;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_level, key_press, key_release, key_long;
  logic          key_code_valid;
  logic [1:0]    key_code;

  key_debounce_multi #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .key_code_valid(key_code_valid), .key_code(key_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled mid-cycle: pulse counts and the edge index of the last one.
  int n_press[NK], n_rel[NK], n_long[NK], t_press[NK], t_rel[NK], t_long[NK];
  int n_lvl1 = 0, t_code = -1, code_seen = -1;
  initial for (int i = 0; i < NK; i++) begin
    n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0;
    t_press[i] = -1; t_rel[i] = -1; t_long[i] = -1;
  end
  always @(negedge clk) begin
    for (int i = 0; i < NK; i++) begin
      if (key_press[i])   begin n_press[i] <= n_press[i] + 1; t_press[i] <= cyc; end
      if (key_release[i]) begin n_rel[i]   <= n_rel[i] + 1;   t_rel[i]   <= cyc; end
      if (key_long[i])    begin n_long[i]  <= n_long[i] + 1;  t_long[i]  <= cyc; end
    end
    if (key_level[1]) n_lvl1 <= n_lvl1 + 1;
    if (key_code_valid) begin t_code <= cyc; code_seen <= int'(key_code); end
  end

  int n_chk = 0, n_fail = 0;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [NK-1:0] keys;
    logic [NK-1:0] level;
    logic [NK-1:0] press;
    logic          valid;
    logic [1:0]    code;
  } vec_t;

  vec_t vecs[20];
  logic [17:0] exp_bus;
  int e, bp, bl, br, bp3;

  initial begin
    // Key 0 pressed from vector 10; press edge k=10 gives key_press after edge 16.
    for (int i = 0; i < 20; i++) begin
      vecs[i].keys  = (i >= 10) ? 4'b1110 : 4'b1111;
      vecs[i].level = (i >= 16) ? 4'b0001 : 4'b0000;
      vecs[i].press = (i == 16) ? 4'b0001 : 4'b0000;
      vecs[i].valid = (i == 16);
      vecs[i].code  = 2'd0;
    end

    rst_n  = 1'b0;
    key_in = '1;
    wait_cyc(3);
    check("reset_outputs", {key_level, key_press, key_release, key_long, key_code_valid, key_code}, '0);
    rst_n = 1'b1;

    // Clean press on key 0.
    for (int i = 0; i < 20; i++) begin
      key_in = vecs[i].keys;
      wait_cyc(1);
      exp_bus = {vecs[i].level, vecs[i].press, 4'b0, 4'b0, vecs[i].valid, vecs[i].code};
      check($sformatf("vec%0d", i),
            {key_level, key_press, key_release, key_long, key_code_valid, key_code}, exp_bus);
    end

    // Reset mid-hold with key 0 still held.
    check("held_level0", key_level[0], 1'b1);
    br = n_rel[0];
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {key_level, key_press, key_release, key_long, key_code_valid, key_code}, '0);
    wait_cyc(2);
    rst_n = 1'b1;
    e = cyc + 1;
    bp = n_press[0];
    wait_cyc(10);
    check("rst_fresh_press_cnt", n_press[0] - bp, 1);
    check("rst_fresh_press_time", t_press[0], e + 6);
    key_in[0] = 1'b1;
    wait_cyc(12);
    check("rst_no_spurious_release", n_rel[0] - br, 1);
    check("rst_release_suppresses_long", n_long[0], 0);
    check("rst_idle_level0", key_level[0], 1'b0);

    // Bounce rejection on key 1: 3 low / 1 high for 40 cycles.
    bp = n_press[1]; bl = n_lvl1; br = n_rel[1];
    for (int r = 0; r < 10; r++) begin
      key_in[1] = 1'b0; wait_cyc(3);
      key_in[1] = 1'b1; wait_cyc(1);
    end
    wait_cyc(6);
    check("bounce_no_press", n_press[1] - bp, 0);
    check("bounce_no_level", n_lvl1 - bl, 0);
    check("bounce_no_release", n_rel[1] - br, 0);

    // Long press on key 2 with a 2-cycle release glitch mid-hold.
    bp = n_press[2]; bl = n_long[2]; br = n_rel[2];
    key_in[2] = 1'b0;
    e = cyc + 1;
    wait_cyc(15);
    key_in[2] = 1'b1; wait_cyc(2);
    key_in[2] = 1'b0; wait_cyc(23);
    key_in[2] = 1'b1;
    bp3 = cyc + 1;
    wait_cyc(12);
    check("long_press_cnt", n_press[2] - bp, 1);
    check("long_press_time", t_press[2], e + 6);
    check("long_cnt", n_long[2] - bl, 1);
    check("long_time", t_long[2], e + 26);
    check("long_release_cnt", n_rel[2] - br, 1);
    check("long_release_time", t_rel[2], bp3 + 6);
    check("long_idle_level", key_level[2], 1'b0);

    // Simultaneous press on keys 1 and 3.
    key_in[1] = 1'b0;
    key_in[3] = 1'b0;
    e = cyc + 1;
    wait_cyc(10);
    check("simul_press1_time", t_press[1], e + 6);
    check("simul_press3_time", t_press[3], e + 6);
    check("simul_code_time", t_code, e + 6);
    check("simul_code", code_seen, 1);
    check("simul_levels", key_level, 4'b1010);
    key_in = '1;
    wait_cyc(12);
    check("final_idle", {key_level, key_press, key_release}, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
